// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the bridge state type used by the slave bridge
// and its address-phase strobe generator.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

endpackage

// File: rtl/ahb_strobe_gen.sv
// Address-phase decode: little-endian byte-lane mask plus size/alignment
// legality flags for one AHB transfer.
module ahb_strobe_gen
    import ahb_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int LANE_W     = $clog2(STRB_W)
) (
    input  logic [LANE_W-1:0] addr_lo_i,
    input  logic [2:0]        size_i,
    output logic [STRB_W-1:0] strobe_o,
    output logic              illegal_size_o,
    output logic              misaligned_o
);

    int nbytes;
    int offset;

    always_comb begin
        strobe_o       = '0;
        misaligned_o   = 1'b0;
        illegal_size_o = (int'(size_i) > LANE_W);
        nbytes         = 1 << size_i;
        offset         = int'(addr_lo_i);

        // Any address bit below the transfer size being set means misaligned
        for (int i = 0; i < LANE_W; i++) begin
            if ((i < int'(size_i)) && addr_lo_i[i]) begin
                misaligned_o = 1'b1;
            end
        end

        if (!illegal_size_o) begin
            for (int j = 0; j < STRB_W; j++) begin
                if ((j >= offset) && (j < offset + nbytes)) begin
                    strobe_o[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_lite_slave_bridge.sv
// AHB-Lite slave front-end turning bus transfers into a request/response
// backend handshake, with strobes, legality checks, wait states and timeout.
module ahb_lite_slave_bridge
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    HSEL,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic [1:0]              HRESP,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    req_valid,
    output logic                    req_write,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH/8-1:0] req_strobe,
    output logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic                    rsp_ready,
    input  logic                    rsp_error,
    input  logic [DATA_WIDTH-1:0]   rsp_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    bridge_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [STRB_W-1:0]       strobe_q, strobe_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [STRB_W-1:0]       strobe;
    logic                    illegal_size;
    logic                    misaligned;
    logic                    trans_active;
    logic                    accept;
    logic                    open_slot;
    logic                    hreadyout;
    hresp_t                  hresp;
    logic [DATA_WIDTH-1:0]   hrdata;
    logic                    valid;

    ahb_strobe_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strobe_gen (
        .addr_lo_i      (HADDR[LANE_W-1:0]),
        .size_i         (HSIZE),
        .strobe_o       (strobe),
        .illegal_size_o (illegal_size),
        .misaligned_o   (misaligned)
    );

    assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign accept       = HSEL && HREADY && trans_active;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            strobe_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    // open_slot marks cycles in which this slave drives HREADYOUT high and
    // may therefore take a new address phase (including pipelined ones).
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        strobe_d  = strobe_q;
        cnt_d     = cnt_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
        valid     = 1'b0;
        open_slot = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                open_slot = 1'b1;
            end
            ST_DATA: begin
                valid     = 1'b1;
                hreadyout = 1'b0;
                if (rsp_ready) begin
                    if (rsp_error) begin
                        hresp   = HRESP_ERROR;
                        state_d = ST_ERR2;
                    end else begin
                        hreadyout = 1'b1;
                        open_slot = 1'b1;
                        state_d   = ST_IDLE;
                        if (!write_q) begin
                            hrdata = rsp_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TO_EN && (cnt_q == CNT_LAST)) begin
                        state_d = ST_ERR1;
                    end
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp     = HRESP_ERROR;
                open_slot = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (open_slot && accept) begin
            addr_d   = HADDR;
            write_d  = HWRITE;
            strobe_d = strobe;
            cnt_d    = '0;
            state_d  = (illegal_size || misaligned) ? ST_ERR1 : ST_DATA;
        end
    end

    assign HREADYOUT  = hreadyout;
    assign HRESP      = hresp;
    assign HRDATA     = hrdata;
    assign req_valid  = valid;
    assign req_write  = write_q;
    assign req_addr   = addr_q;
    assign req_strobe = strobe_q;
    assign req_wdata  = HWDATA;

endmodule

// File: tb/tb_ahb_lite_slave_bridge.sv
// Directed self-checking bench for ahb_lite_slave_bridge (32-bit data,
// TIMEOUT=4), single slave with HREADY looped back from HREADYOUT.
module tb_ahb_lite_slave_bridge;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          HSEL;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [AW-1:0] HADDR;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [1:0]    HRESP;
    logic [DW-1:0] HRDATA;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_strobe;
    logic [DW-1:0] req_wdata;
    logic          rsp_ready;
    logic          rsp_error;
    logic [DW-1:0] rsp_rdata;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 CLK = ~CLK;
    assign HREADY = HREADYOUT;

    ahb_lite_slave_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .HSEL       (HSEL),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HADDR      (HADDR),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_strobe (req_strobe),
        .req_wdata  (req_wdata),
        .rsp_ready  (rsp_ready),
        .rsp_error  (rsp_error),
        .rsp_rdata  (rsp_rdata)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [AW-1:0] addr);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
    endtask

    task automatic setBackend(input logic ready, input logic err, input logic [DW-1:0] rdata);
        rsp_ready = ready;
        rsp_error = err;
        rsp_rdata = rdata;
    endtask

    task automatic idleBus();
        applyStimulus(1'b0, HTRANS_IDLE, 1'b0, 3'd0, '0);
    endtask

    // Registers update at the posedge; inputs change 1 time unit later.
    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    logic [2:0]  strbSize [5] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    logic [31:0] strbAddr [5] = '{32'h40, 32'h43, 32'h42, 32'h40, 32'h44};
    logic [3:0]  strbMask [5] = '{4'b0001, 4'b1000, 4'b1100, 4'b0011, 4'b1111};

    initial begin
        nRST   = 1'b0;
        HWDATA = '0;
        idleBus();
        setBackend(1'b0, 1'b0, '0);

        // Reset values
        nextCycle();
        settle();
        checkOutput("rst_hreadyout", HREADYOUT, 1);
        checkOutput("rst_hresp", HRESP, 0);
        checkOutput("rst_hrdata", HRDATA, 0);
        checkOutput("rst_req_valid", req_valid, 0);
        checkOutput("rst_req_strobe", req_strobe, 0);
        checkOutput("rst_req_addr", req_addr, 0);
        nextCycle();
        nRST = 1'b1;

        // Zero-wait word read
        nextCycle();
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h10);
        setBackend(1'b1, 1'b0, 32'hDEADBEEF);
        settle();
        checkOutput("rd_addrphase_hrdata", HRDATA, 0);
        nextCycle();
        idleBus();
        settle();
        checkOutput("rd_req_valid", req_valid, 1);
        checkOutput("rd_req_addr", req_addr, 32'h10);
        checkOutput("rd_req_strobe", req_strobe, 4'b1111);
        checkOutput("rd_req_write", req_write, 0);
        checkOutput("rd_hreadyout", HREADYOUT, 1);
        checkOutput("rd_hresp", HRESP, 0);
        checkOutput("rd_hrdata", HRDATA, 32'hDEADBEEF);
        nextCycle();
        settle();
        checkOutput("rd_after_valid", req_valid, 0);
        checkOutput("rd_after_hrdata", HRDATA, 0);

        // Byte write at 0x3, three backend wait states
        nextCycle();
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, 3'd0, 32'h3);
        setBackend(1'b0, 1'b0, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            idleBus();
            HWDATA = 32'h11223344 + i;
            settle();
            checkOutput("wr_wait_hreadyout", HREADYOUT, 0);
            checkOutput("wr_wait_hresp", HRESP, 0);
            checkOutput("wr_wait_valid", req_valid, 1);
            checkOutput("wr_wait_strobe", req_strobe, 4'b1000);
            checkOutput("wr_wait_wdata", req_wdata, 32'h11223344 + i);
        end
        nextCycle();
        setBackend(1'b1, 1'b0, 32'hFFFFFFFF);
        settle();
        checkOutput("wr_done_hreadyout", HREADYOUT, 1);
        checkOutput("wr_done_hresp", HRESP, 0);
        checkOutput("wr_done_write", req_write, 1);
        checkOutput("wr_done_addr", req_addr, 32'h3);
        checkOutput("wr_done_hrdata", HRDATA, 0);

        // Misaligned halfword
        nextCycle();
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd1, 32'h1);
        nextCycle();
        idleBus();
        settle();
        checkOutput("mis_err1_hreadyout", HREADYOUT, 0);
        checkOutput("mis_err1_hresp", HRESP, 1);
        checkOutput("mis_err1_valid", req_valid, 0);
        nextCycle();
        settle();
        checkOutput("mis_err2_hreadyout", HREADYOUT, 1);
        checkOutput("mis_err2_hresp", HRESP, 1);
        checkOutput("mis_err2_valid", req_valid, 0);
        nextCycle();
        settle();
        checkOutput("mis_idle_hresp", HRESP, 0);

        // Doubleword on a 32-bit bus is an illegal size
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd3, 32'h0);
        nextCycle();
        idleBus();
        settle();
        checkOutput("size_err1_hreadyout", HREADYOUT, 0);
        checkOutput("size_err1_hresp", HRESP, 1);
        checkOutput("size_err1_valid", req_valid, 0);
        nextCycle();
        settle();
        checkOutput("size_err2_hresp", HRESP, 1);

        // Timeout, then a NONSEQ issued during ERR2
        nextCycle();
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h20);
        setBackend(1'b0, 1'b0, '0);
        for (int i = 0; i < TO; i++) begin
            nextCycle();
            idleBus();
            settle();
            checkOutput("to_wait_valid", req_valid, 1);
            checkOutput("to_wait_hreadyout", HREADYOUT, 0);
            checkOutput("to_wait_hresp", HRESP, 0);
        end
        nextCycle();
        settle();
        checkOutput("to_err1_valid", req_valid, 0);
        checkOutput("to_err1_hreadyout", HREADYOUT, 0);
        checkOutput("to_err1_hresp", HRESP, 1);
        nextCycle();
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h24);
        settle();
        checkOutput("to_err2_hreadyout", HREADYOUT, 1);
        checkOutput("to_err2_hresp", HRESP, 1);
        nextCycle();
        idleBus();
        setBackend(1'b1, 1'b0, 32'hCAFEF00D);
        settle();
        checkOutput("to_next_addr", req_addr, 32'h24);
        checkOutput("to_next_hresp", HRESP, 0);
        checkOutput("to_next_hrdata", HRDATA, 32'hCAFEF00D);

        // Back-to-back reads, error on the second
        nextCycle();
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h0);
        nextCycle();
        applyStimulus(1'b1, HTRANS_SEQ, 1'b0, 3'd2, 32'h4);
        setBackend(1'b1, 1'b0, 32'h01010101);
        settle();
        checkOutput("b2b_first_addr", req_addr, 32'h0);
        checkOutput("b2b_first_hreadyout", HREADYOUT, 1);
        checkOutput("b2b_first_hrdata", HRDATA, 32'h01010101);
        nextCycle();
        idleBus();
        setBackend(1'b1, 1'b1, 32'h02020202);
        settle();
        checkOutput("b2b_second_valid", req_valid, 1);
        checkOutput("b2b_second_addr", req_addr, 32'h4);
        checkOutput("b2b_second_hreadyout", HREADYOUT, 0);
        checkOutput("b2b_second_hresp", HRESP, 1);
        checkOutput("b2b_second_hrdata", HRDATA, 0);
        nextCycle();
        setBackend(1'b0, 1'b0, '0);
        settle();
        checkOutput("b2b_err2_hreadyout", HREADYOUT, 1);
        checkOutput("b2b_err2_hresp", HRESP, 1);
        checkOutput("b2b_err2_valid", req_valid, 0);

        // BUSY while selected and NONSEQ while deselected are both ignored
        nextCycle();
        applyStimulus(1'b1, HTRANS_BUSY, 1'b0, 3'd2, 32'h30);
        nextCycle();
        applyStimulus(1'b0, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h34);
        settle();
        checkOutput("busy_valid", req_valid, 0);
        checkOutput("busy_hreadyout", HREADYOUT, 1);
        nextCycle();
        idleBus();
        settle();
        checkOutput("desel_valid", req_valid, 0);

        // Strobe lanes for assorted sizes and offsets
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, strbSize[k], strbAddr[k]);
            setBackend(1'b1, 1'b0, '0);
            nextCycle();
            idleBus();
            settle();
            checkOutput($sformatf("strobe_%0d", k), req_strobe, strbMask[k]);
            checkOutput($sformatf("strobe_valid_%0d", k), req_valid, 1);
        end

        // Asynchronous reset in the middle of a data phase
        nextCycle();
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h8);
        setBackend(1'b0, 1'b0, '0);
        nextCycle();
        idleBus();
        settle();
        checkOutput("arst_pre_valid", req_valid, 1);
        nRST = 1'b0;
        #1;
        checkOutput("arst_valid", req_valid, 0);
        checkOutput("arst_hreadyout", HREADYOUT, 1);
        checkOutput("arst_hresp", HRESP, 0);
        nextCycle();
        nRST = 1'b1;
        applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h8);
        nextCycle();
        idleBus();
        setBackend(1'b1, 1'b0, 32'h55AA55AA);
        settle();
        checkOutput("arst_after_addr", req_addr, 32'h8);
        checkOutput("arst_after_hrdata", HRDATA, 32'h55AA55AA);
        checkOutput("arst_after_strobe", req_strobe, 4'b1111);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/ahb_lite_slave_bridge.md
Name: ahb_lite_slave_bridge

Overview:
Parametrised AHB-Lite slave front-end that converts bus transfers into a simple request/response backend handshake for peripherals, memories and CSR blocks. It generalises the fixed 32-bit ahb_if slave view with configurable address and data widths, and adds behaviour that view lacks:
- byte-lane strobe generation
- alignment and size checking
- backend wait-state insertion
- a response timeout
- the two-cycle AHB ERROR response

It sits between the bus mux/decoder and one slave's register or memory logic.

Parameters:
ADDR_WIDTH, 32, width of HADDR and req_addr
DATA_WIDTH, 32, width of HWDATA/HRDATA/req_wdata/rsp_rdata; legal values 32 or 64
TIMEOUT, 16, data-phase cycles allowed before a forced ERROR; 0 disables the timeout

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HTRANS  in  2  transfer type
HWRITE  in  1  write/read
HSIZE  in  3  transfer size
HADDR  in  ADDR_WIDTH  address
HWDATA  in  DATA_WIDTH  write data (data phase)
HREADY  in  1  bus-level ready
HREADYOUT  out  1  slave ready
HRESP  out  2  00=OKAY, 01=ERROR
HRDATA  out  DATA_WIDTH  read data
req_valid  out  1  backend request active
req_write  out  1  request is a write
req_addr  out  ADDR_WIDTH  captured address
req_strobe  out  DATA_WIDTH/8  byte enables
req_wdata  out  DATA_WIDTH  equals HWDATA
rsp_ready  in  1  backend completes the request this cycle
rsp_error  in  1  backend error, qualified by rsp_ready
rsp_rdata  in  DATA_WIDTH  read data, qualified by rsp_ready

Behaviour:
- Clock and reset: single clock CLK. nRST is asynchronous, active-low; assertion forces state IDLE in any state.
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, req_valid=0, req_write=0, req_addr=0, req_strobe=0, timeout counter=0.
- Address-phase accept: HSEL && HREADY && HTRANS[1] (NONSEQ/SEQ). Capture HADDR, HWRITE, HSIZE into registers.
- IDLE/BUSY transfers: HTRANS=00 or 01 while selected gives a zero-wait OKAY; no backend request.
- Address-phase check (in ahb_strobe_gen) on accept:
  - HSIZE > log2(DATA_WIDTH/8) → ERR1, no backend request.
  - Address not aligned to HSIZE → ERR1, no backend request.
  - Otherwise → DATA.
- States:
  - IDLE: HREADYOUT=1, HRESP=00. On a legal accept → DATA.
  - DATA: req_valid=1, req_addr/req_write/req_strobe from captured registers, req_wdata=HWDATA. HREADYOUT=rsp_ready (combinational; zero wait states when the backend answers in the same cycle).
    - rsp_ready && !rsp_error: HRESP=00. On a read, HRDATA=rsp_rdata. Then → DATA if a new legal accept occurs in the same cycle (back-to-back pipelining), else IDLE.
    - rsp_ready && rsp_error: treated as not ready this cycle (HREADYOUT=0, HRESP=01); → ERR2.
    - !rsp_ready: counter increments. If TIMEOUT≠0 and counter==TIMEOUT-1: drop req_valid next cycle; → ERR1.
  - ERR1: HREADYOUT=0, HRESP=01, req_valid=0 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. A new accept in this cycle is honoured (→ DATA or ERR1), else → IDLE.
- Error responses: every error is exactly two cycles; HRESP stays 01 across both.
- Timeout counter: cleared on every entry to DATA; width $clog2(TIMEOUT+1).
- HRDATA: 0 whenever not completing a read.
- Strobes (little-endian): lane mask = ((1<<(1<<HSIZE))-1) << (HADDR mod (DATA_WIDTH/8)).
  - Example, 32-bit: HSIZE=0 at addr 0x3 → 1000; HSIZE=1 at 0x2 → 1100; HSIZE=2 → 1111.
- HSEL low in address phase: the captured transfer is ignored. A transfer already in DATA completes regardless of HSEL.
- Reset mid-DATA: req_valid drops immediately (asynchronous); no response is issued for the aborted transfer.

Decomposition:
- Package ahb_pkg:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HRESP encodings OKAY/ERROR (2-bit).
  - HSIZE encodings BYTE/HALF/WORD/DWORD.
  - bridge_state_t {IDLE, DATA, ERR1, ERR2}.
- Sub-module ahb_strobe_gen (combinational, parametrised by DATA_WIDTH): HADDR low bits + HSIZE → strobe mask, plus illegal_size and misaligned flags.

Test Plan:
- Read with rsp_ready held high, addr 0x10, HSIZE=2: one data-phase cycle, HREADYOUT=1, HRESP=00, HRDATA=rsp_rdata=0xDEADBEEF, req_strobe=1111.
- Byte write at 0x3, rsp_ready asserted after 3 cycles: HREADYOUT low for 3 cycles, req_strobe=1000, req_wdata=HWDATA throughout, then OKAY.
- Halfword at 0x1: ERR1 then ERR2 (HREADYOUT 0 then 1, HRESP=01 both cycles); req_valid never asserts.
- TIMEOUT=4, rsp_ready never asserted: req_valid high for 4 cycles, then two-cycle ERROR; next NONSEQ in ERR2 is accepted and completes OKAY.
- Back-to-back NONSEQ reads at 0x0/0x4 with zero-wait backend: two consecutive OKAY data phases, no idle cycle between them; rsp_error on the second gives the two-cycle ERROR.
- nRST asserted mid-DATA: HREADYOUT=1, HRESP=00, req_valid=0 immediately; a NONSEQ issued after reset release is serviced normally.
